// File: rtl/axi_rd_master.sv
// axi_rd_master: single-outstanding AXI4 read master that turns client requests into INCR bursts.
//   client request : req_valid/req_ready/req_addr/req_len (len = beats-1)
//   client response: rsp_valid/rsp_ready/rsp_data/rsp_last/rsp_err (one registered beat)
//   AXI AR channel : ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID/ARREADY
//   AXI R channel  : RID/RDATA/RRESP/RLAST/RVALID/RREADY
//   busy           : high whenever a burst is in flight (state != IDLE)
module axi_rd_master #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int MASTER_ID = 0
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [LEN_W-1:0]  ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q, beat_cnt;
  logic              hs, last_beat;
  assign last_beat = beat_cnt == len_q;
  assign hs        = RVALID & RREADY;
  assign ARID      = ID_W'(MASTER_ID);
  assign ARADDR    = addr_q;
  assign ARLEN     = len_q;
  assign ARSIZE    = 3'b010;
  assign ARBURST   = 2'b01;
  assign busy      = state != IDLE;
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        state_nx  = req_valid ? ADDR : IDLE;
      end
      ADDR: begin
        ARVALID  = 1'b1;
        state_nx = ARREADY ? DATA : ADDR;
      end
      DATA: begin
        // accept a beat only if the output register is empty or being drained this cycle
        RREADY   = ~rsp_valid | rsp_ready;
        state_nx = (RVALID & (~rsp_valid | rsp_ready) & (last_beat | RLAST)) ? IDLE : DATA;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        addr_q <= req_addr;
        len_q  <= req_len;
      end
      if (state == ADDR && ARREADY) beat_cnt <= '0;
      else if (hs && !last_beat) beat_cnt <= beat_cnt + LEN_W'(1);
      rsp_valid <= hs | (rsp_valid & ~rsp_ready);
      if (hs) begin
        rsp_data <= RDATA;
        rsp_last <= last_beat | RLAST;
        // RLAST must coincide exactly with the expected final beat
        rsp_err  <= (RRESP != 2'b00) | (RID != ID_W'(MASTER_ID)) | (RLAST != last_beat);
      end
    end
  end
endmodule

// File: tb/tb_axi_rd_master.sv
// tb_axi_rd_master: directed self-checking bench for axi_rd_master.
module tb_axi_rd_master;
  logic        ACLK = 0, ARESETn;
  logic        req_valid, req_ready, rsp_valid, rsp_last, rsp_err, rsp_ready;
  logic [31:0] req_addr, rsp_data, ARADDR, RDATA;
  logic [3:0]  req_len, ARID, ARLEN, RID;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST, RRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, busy;
  int          chk = 0, pass = 0;
  axi_rd_master #(.MASTER_ID(5)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .busy(busy)
  );
  always #5 ACLK = ~ACLK;
  task automatic step;
    @(posedge ACLK);
    #1;
  endtask
  task automatic issue(input logic [31:0] a, input logic [3:0] l);
    req_valid = 1; req_addr = a; req_len = l;
    step;
    req_valid = 0;
  endtask
  task automatic test_reset;
    #12;
    chk++; if (ARVALID !== 1'b0) $display("FAIL rst_arvalid got=%0h exp=0", ARVALID); else pass++;
    chk++; if (RREADY !== 1'b0) $display("FAIL rst_rready got=%0h exp=0", RREADY); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0h exp=0", busy); else pass++;
    chk++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got=%0h exp=1", req_ready); else pass++;
    chk++; if (ARID !== 4'd5) $display("FAIL rst_arid got=%0h exp=5", ARID); else pass++;
    chk++; if (ARADDR !== 32'h0) $display("FAIL rst_araddr got=%0h exp=0", ARADDR); else pass++;
    chk++; if (ARLEN !== 4'h0) $display("FAIL rst_arlen got=%0h exp=0", ARLEN); else pass++;
    chk++; if (ARSIZE !== 3'b010) $display("FAIL rst_arsize got=%0h exp=2", ARSIZE); else pass++;
    chk++; if (ARBURST !== 2'b01) $display("FAIL rst_arburst got=%0h exp=1", ARBURST); else pass++;
    chk++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got=%0h exp=0", rsp_valid); else pass++;
    chk++; if ({rsp_data, rsp_last, rsp_err} !== 34'h0) $display("FAIL rst_rsp_regs got=%0h exp=0", {rsp_data, rsp_last, rsp_err}); else pass++;
    @(posedge ACLK); #1;
    ARESETn = 1;
    step;
  endtask
  task automatic test_single;
    issue(32'h100, 0);
    chk++; if (ARVALID !== 1'b1) $display("FAIL single_arvalid got=%0h exp=1", ARVALID); else pass++;
    chk++; if (ARADDR !== 32'h100) $display("FAIL single_araddr got=%0h exp=100", ARADDR); else pass++;
    chk++; if (ARLEN !== 4'h0) $display("FAIL single_arlen got=%0h exp=0", ARLEN); else pass++;
    chk++; if (busy !== 1'b1 || req_ready !== 1'b0) $display("FAIL single_addr_busy got=%0h/%0h exp=1/0", busy, req_ready); else pass++;
    ARREADY = 1;
    step;
    ARREADY = 0;
    RVALID = 1; RDATA = 32'hDEADBEEF; RLAST = 1; rsp_ready = 0;
    #1;
    chk++; if (RREADY !== 1'b1 || ARVALID !== 1'b0) $display("FAIL single_data_rready got=%0h/%0h exp=1/0", RREADY, ARVALID); else pass++;
    step;
    RVALID = 0; RLAST = 0;
    chk++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid got=%0h exp=1", rsp_valid); else pass++;
    chk++; if (rsp_data !== 32'hDEADBEEF) $display("FAIL single_rsp_data got=%0h exp=deadbeef", rsp_data); else pass++;
    chk++; if (rsp_last !== 1'b1 || rsp_err !== 1'b0) $display("FAIL single_last_err got=%0h/%0h exp=1/0", rsp_last, rsp_err); else pass++;
    chk++; if (busy !== 1'b0 || req_ready !== 1'b1) $display("FAIL single_idle got=%0h/%0h exp=0/1", busy, req_ready); else pass++;
    issue(32'h180, 0);
    chk++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF) $display("FAIL pending_hold got=%0h/%0h exp=1/deadbeef", rsp_valid, rsp_data); else pass++;
    chk++; if (busy !== 1'b1 || ARADDR !== 32'h180) $display("FAIL pending_accept got=%0h/%0h exp=1/180", busy, ARADDR); else pass++;
    ARREADY = 1;
    step;
    ARREADY = 0;
    RVALID = 1; RDATA = 32'h11; RLAST = 1;
    #1;
    chk++; if (RREADY !== 1'b0) $display("FAIL full_rready got=%0h exp=0", RREADY); else pass++;
    step;
    chk++; if (rsp_data !== 32'hDEADBEEF || busy !== 1'b1) $display("FAIL full_no_capture got=%0h/%0h exp=deadbeef/1", rsp_data, busy); else pass++;
    rsp_ready = 1;
    #1;
    chk++; if (RREADY !== 1'b1) $display("FAIL drain_rready got=%0h exp=1", RREADY); else pass++;
    step;
    RVALID = 0; RLAST = 0;
    chk++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h11) $display("FAIL reload got=%0h/%0h exp=1/11", rsp_valid, rsp_data); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL reload_idle got=%0h exp=0", busy); else pass++;
    step;
    chk++; if (rsp_valid !== 1'b0) $display("FAIL consume_clear got=%0h exp=0", rsp_valid); else pass++;
    rsp_ready = 0;
  endtask
  task automatic test_burst4;
    rsp_ready = 1;
    issue(32'h200, 3);
    ARREADY = 1;
    step;
    ARREADY = 0;
    for (int i = 0; i < 4; i++) begin
      RVALID = 1; RDATA = 32'hA000 + i; RLAST = (i == 3);
      step;
      chk++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hA000 + i) $display("FAIL burst_beat%0d got=%0h/%0h exp=1/%0h", i, rsp_valid, rsp_data, 32'hA000 + i); else pass++;
      chk++; if (rsp_last !== (i == 3) || busy !== (i != 3)) $display("FAIL burst_last_busy%0d got=%0h/%0h exp=%0h/%0h", i, rsp_last, busy, i == 3, i != 3); else pass++;
    end
    RVALID = 0; RLAST = 0;
    step;
    chk++; if (rsp_valid !== 1'b0) $display("FAIL burst_drain got=%0h exp=0", rsp_valid); else pass++;
    rsp_ready = 0;
  endtask
  task automatic test_backpressure;
    int k = 0, got = 0, cyc = 0;
    issue(32'h300, 3);
    ARREADY = 1;
    step;
    ARREADY = 0;
    while (got < 4 && cyc < 20) begin
      rsp_ready = !(cyc >= 1 && cyc <= 3);
      RVALID = (k < 4); RDATA = 32'hB0 + k; RLAST = (k == 3);
      #1;
      if (rsp_valid && !rsp_ready) begin
        chk++; if (RREADY !== 1'b0) $display("FAIL bp_rready cyc%0d got=%0h exp=0", cyc, RREADY); else pass++;
      end
      if (rsp_valid && rsp_ready) begin
        chk++; if (rsp_data !== 32'hB0 + got) $display("FAIL bp_order%0d got=%0h exp=%0h", got, rsp_data, 32'hB0 + got); else pass++;
        got++;
      end
      if (RVALID && RREADY) k++;
      cyc++;
      step;
    end
    RVALID = 0; RLAST = 0;
    chk++; if (got !== 4) $display("FAIL bp_count got=%0d exp=4", got); else pass++;
    chk++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_end got=%0h/%0h exp=0/0", rsp_valid, busy); else pass++;
    rsp_ready = 0;
  endtask
  task automatic test_errors;
    rsp_ready = 1;
    for (int m = 0; m < 2; m++) begin
      issue(32'h1000, 3);
      ARREADY = 1;
      step;
      ARREADY = 0;
      for (int i = 0; i < 4; i++) begin
        RVALID = 1; RDATA = i; RLAST = (i == 3);
        RRESP = (m == 0 && i == 1) ? 2'b10 : 2'b00;
        RID = (m == 1 && i == 1) ? 4'd6 : 4'd5;
        step;
        chk++; if (rsp_err !== (i == 1)) $display("FAIL err_mode%0d_beat%0d got=%0h exp=%0h", m, i, rsp_err, i == 1); else pass++;
      end
      RVALID = 0; RLAST = 0; RRESP = 0; RID = 5;
      step;
    end
    issue(32'h2000, 3);
    ARREADY = 1;
    step;
    ARREADY = 0;
    RVALID = 1; RDATA = 32'h1; RLAST = 0;
    step;
    chk++; if (rsp_err !== 1'b0 || rsp_last !== 1'b0) $display("FAIL early_beat0 got=%0h/%0h exp=0/0", rsp_err, rsp_last); else pass++;
    RDATA = 32'h2; RLAST = 1;
    step;
    RVALID = 0; RLAST = 0;
    chk++; if (rsp_last !== 1'b1 || rsp_err !== 1'b1) $display("FAIL early_last got=%0h/%0h exp=1/1", rsp_last, rsp_err); else pass++;
    chk++; if (busy !== 1'b0 || req_ready !== 1'b1) $display("FAIL early_idle got=%0h/%0h exp=0/1", busy, req_ready); else pass++;
    step;
    rsp_ready = 0;
  endtask
  task automatic test_arready_stall;
    issue(32'h400, 2);
    RVALID = 1; RDATA = 32'h55;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk++; if (ARVALID !== 1'b1 || ARADDR !== 32'h400 || ARLEN !== 4'd2) $display("FAIL stall_ar%0d got=%0h/%0h/%0h exp=1/400/2", c, ARVALID, ARADDR, ARLEN); else pass++;
      chk++; if (RREADY !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL stall_r%0d got=%0h/%0h exp=0/0", c, RREADY, rsp_valid); else pass++;
      step;
    end
    RVALID = 0;
    ARREADY = 1;
    step;
    ARREADY = 0;
    rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      RVALID = 1; RDATA = 32'hE0 + i; RLAST = (i == 2);
      step;
      chk++; if (rsp_data !== 32'hE0 + i) $display("FAIL stall_beat%0d got=%0h exp=%0h", i, rsp_data, 32'hE0 + i); else pass++;
    end
    RVALID = 0; RLAST = 0;
    chk++; if (busy !== 1'b0) $display("FAIL stall_done got=%0h exp=0", busy); else pass++;
    step;
    rsp_ready = 0;
  endtask
  task automatic test_reset_mid;
    issue(32'h500, 3);
    ARREADY = 1;
    step;
    ARREADY = 0;
    rsp_ready = 1;
    RVALID = 1; RDATA = 32'hC0; RLAST = 0;
    step;
    RDATA = 32'hC1;
    #2;
    ARESETn = 0;
    #1;
    chk++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_last !== 1'b0) $display("FAIL mid_rst_rsp got=%0h/%0h/%0h exp=0/0/0", rsp_valid, rsp_data, rsp_last); else pass++;
    chk++; if (busy !== 1'b0 || RREADY !== 1'b0 || ARVALID !== 1'b0) $display("FAIL mid_rst_ctl got=%0h/%0h/%0h exp=0/0/0", busy, RREADY, ARVALID); else pass++;
    chk++; if (ARADDR !== 32'h0 || ARLEN !== 4'h0 || req_ready !== 1'b1) $display("FAIL mid_rst_ar got=%0h/%0h/%0h exp=0/0/1", ARADDR, ARLEN, req_ready); else pass++;
    step;
    chk++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mid_rst_hold got=%0h/%0h exp=0/0", rsp_valid, busy); else pass++;
    ARESETn = 1;
    step;
    chk++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL idle_ignore_r got=%0h/%0h exp=0/0", rsp_valid, busy); else pass++;
    RVALID = 0;
    issue(32'h600, 0);
    chk++; if (ARADDR !== 32'h600 || ARVALID !== 1'b1) $display("FAIL post_rst_ar got=%0h/%0h exp=600/1", ARADDR, ARVALID); else pass++;
    ARREADY = 1;
    step;
    ARREADY = 0;
    RVALID = 1; RDATA = 32'h77; RLAST = 1;
    step;
    RVALID = 0; RLAST = 0;
    chk++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h77) $display("FAIL post_rst_data got=%0h/%0h exp=1/77", rsp_valid, rsp_data); else pass++;
    chk++; if (rsp_last !== 1'b1 || rsp_err !== 1'b0 || busy !== 1'b0) $display("FAIL post_rst_flags got=%0h/%0h/%0h exp=1/0/0", rsp_last, rsp_err, busy); else pass++;
    step;
    rsp_ready = 0;
  endtask
  initial begin
    ARESETn = 0; req_valid = 0; req_addr = 0; req_len = 0; rsp_ready = 0;
    ARREADY = 0; RID = 5; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
    test_reset;
    test_single;
    test_burst4;
    test_backpressure;
    test_errors;
    test_arready_stall;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/axi_rd_master.md
AXI_RD_MASTER -- requirements
Module: axi_rd_master

Interface
REQ-001 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter LEN_W, default 4, burst length field width.
REQ-005 SHALL have parameter MASTER_ID, default 0, ID driven on ARID and expected on RID.
REQ-006 SHALL have port ACLK  in  1  clock; all state updates on its rising edge.
REQ-007 SHALL have port ARESETn  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports req_valid in 1, req_ready out 1, req_addr in ADDR_W, req_len in LEN_W; together these form the client read request, with req_len meaning beats-1.
REQ-009 SHALL have ports rsp_valid out 1, rsp_data out DATA_W, rsp_last out 1, rsp_err out 1, rsp_ready in 1; together these form the client beat response.
REQ-010 SHALL have ports ARID out ID_W, ARADDR out ADDR_W, ARLEN out LEN_W, ARSIZE out 3, ARBURST out 2, ARVALID out 1, ARREADY in 1; together these form the AXI read-address channel.
REQ-011 SHALL have ports RID in ID_W, RDATA in DATA_W, RRESP in 2, RLAST in 1, RVALID in 1, RREADY out 1; together these form the AXI read-data channel.
REQ-012 SHALL have port busy  out  1, high in any state other than IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, ADDR and DATA, with a single outstanding burst.
REQ-014 IDLE SHALL drive req_ready=1; on req_valid it SHALL latch req_addr and req_len, then go to ADDR on the next cycle.
REQ-015 ADDR SHALL drive ARVALID=1, ARID=MASTER_ID, ARADDR=latched addr, ARLEN=latched len, ARSIZE=3'b010 and ARBURST=2'b01, all held stable until ARREADY.
REQ-016 ADDR with ARREADY=1 SHALL go to DATA and clear beat_cnt (LEN_W bits) to 0.
REQ-017 ARVALID SHALL be 0 outside ADDR; req_ready SHALL be 0 outside IDLE.
REQ-018 DATA SHALL drive RREADY = ~rsp_valid | rsp_ready; RREADY SHALL be 0 in IDLE and ADDR.
REQ-019 An R handshake (RVALID&RREADY) SHALL load rsp_data=RDATA and set rsp_valid=1 on the next edge, giving 1-cycle latency from handshake to rsp_valid.
REQ-020 The same handshake SHALL set rsp_last = (beat_cnt==len) | RLAST.
REQ-021 The same handshake SHALL set rsp_err = (RRESP!=0) | (RID!=MASTER_ID) | (RLAST != (beat_cnt==len)).
REQ-022 beat_cnt SHALL increment by 1 per R handshake and never wraps, because the burst ends at beat_cnt==len.
REQ-023 A handshake with beat_cnt==len or RLAST=1 SHALL return the FSM to IDLE, so an early RLAST terminates the burst with rsp_err=1.
REQ-024 When rsp_valid&rsp_ready holds without a new R handshake, rsp_valid SHALL clear to 0 next cycle.
REQ-025 Simultaneous consume and new handshake SHALL reload the output register with rsp_valid staying 1 and no bubble.
REQ-026 rsp_data, rsp_last and rsp_err SHALL hold while rsp_valid=1 and rsp_ready=0.
REQ-027 A new request SHALL be accepted in IDLE even while the final beat of the previous burst is still pending in the output register.
REQ-028 RVALID in IDLE or ADDR SHALL be ignored: no data captured, no state change.
REQ-029 With rsp_ready held at 1 and RVALID at 1, throughput SHALL be one beat per cycle.

Reset
REQ-030 ARESETn low SHALL immediately force state=IDLE, beat_cnt=0 and latched addr/len=0.
REQ-031 ARESETn low SHALL immediately force rsp_valid=0, rsp_data=0, rsp_last=0 and rsp_err=0.
REQ-032 Resulting output values during reset SHALL be ARVALID=0, RREADY=0, busy=0, req_ready=1, ARID=MASTER_ID, ARADDR=0, ARLEN=0, ARSIZE=3'b010, ARBURST=2'b01.
REQ-033 Reset asserted mid-burst SHALL abandon the burst with no further R beats consumed; after release, operation SHALL resume in IDLE.

Verification
REQ-034 Single beat: req_addr=0x0000_0100, len=0, ARREADY on first ARVALID cycle, RDATA=0xDEADBEEF with RLAST=1 -> ARADDR=0x100, ARLEN=0, rsp_data=0xDEADBEEF, rsp_last=1, rsp_err=0, FSM back in IDLE.
REQ-035 4-beat burst, len=3, rsp_ready=1, RVALID continuous -> 4 consecutive rsp_valid cycles, rsp_last only on beat 4, busy low 1 cycle after beat 4 handshake.
REQ-036 Backpressure: rsp_ready=0 for 3 cycles during a 4-beat burst -> RREADY=0 while rsp_valid=1, no beat lost or duplicated, data order preserved.
REQ-037 Errors: RRESP=2'b10 on beat 2, and separately RID=MASTER_ID+1 -> rsp_err=1 on that beat only; early RLAST on beat 2 of len=3 -> rsp_last=1, rsp_err=1, FSM in IDLE.
REQ-038 ARREADY held 0 for 5 cycles -> ARVALID/ARADDR/ARLEN stable for 5 cycles, RREADY=0 throughout.
REQ-039 ARESETn pulsed low during beat 2 of 4 -> all outputs at reset values immediately; a new len=0 request after release completes normally.
